// File: rtl/mdio_peripheral.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_peripheral
//  Description : Clause-22 MDIO responder. Oversamples MDC/MDIO in the clk
//                domain, decodes frames addressed to phy_addr, issues
//                register-port write/read strobes and drives read data.
//                Optional feature macro: MDIO_BROADCAST_EN (PHYAD 0 also
//                matches for writes).
//  Revision    : 1.0 - initial release
// ============================================================================
module mdio_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic [4:0]  phy_addr,
  output logic [4:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  output logic        busy,
  output logic        frame_err
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYC + 2);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam bit              TO_EN   = (TIMEOUT_CYC != 0);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_OPCODE, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA, S_SKIP
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] mdc_sync_q, mdc_sync_d;
  logic [SYNC_STAGES-1:0] mdio_sync_q, mdio_sync_d;
  logic                   mdc_prev_q, mdc_prev_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [15:0]            sh_q, sh_d;
  logic [15:0]            tx_q, tx_d;
  logic                   rd_op_q, rd_op_d;
  logic                   match_q, match_d;
  logic                   busy_q, busy_d;
  logic                   oe_q, oe_d;
  logic                   out_q, out_d;
  logic [4:0]             reg_addr_q, reg_addr_d;
  logic [15:0]            wdata_q, wdata_d;
  logic                   wr_q, wr_d;
  logic                   rd_q, rd_d;
  logic                   ferr_q, ferr_d;
  logic [TO_W-1:0]        to_q, to_d;

  logic        mdc_s, mdio_s, rise, fall;
  logic [15:0] sh_next;

  assign mdc_s   = mdc_sync_q[SYNC_STAGES-1];
  assign mdio_s  = mdio_sync_q[SYNC_STAGES-1];
  assign rise    = mdc_s & ~mdc_prev_q;
  assign fall    = ~mdc_s & mdc_prev_q;
  assign sh_next = {sh_q[14:0], mdio_s};

  // Frame decoder: advances on detected mdc rises, drives the pad on falls.
  always_comb begin
    state_d     = state_q;
    mdc_sync_d  = {mdc_sync_q[SYNC_STAGES-2:0], mdc};
    mdio_sync_d = {mdio_sync_q[SYNC_STAGES-2:0], mdio_in};
    mdc_prev_d  = mdc_s;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    tx_d        = tx_q;
    rd_op_d     = rd_op_q;
    match_d     = match_q;
    busy_d      = busy_q;
    oe_d        = oe_q;
    out_d       = out_q;
    reg_addr_d  = reg_addr_q;
    wdata_d     = wdata_q;
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    ferr_d      = 1'b0;
    to_d        = '0;

    // Read data is presented one clk after the reg_rd strobe.
    if (rd_q) tx_d = reg_rdata;

    if (rise) begin
      case (state_q)
        S_IDLE: begin
          if (!mdio_s) state_d = S_START;
        end
        S_START: begin
          if (mdio_s) begin
            state_d = S_OPCODE;
            busy_d  = 1'b1;
            cnt_d   = 5'd0;
          end
        end
        S_OPCODE: begin
          sh_d  = sh_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd1) begin
            cnt_d = 5'd0;
            if (sh_next[1:0] == 2'b01) begin
              rd_op_d = 1'b0;
              state_d = S_PHYAD;
            end else if (sh_next[1:0] == 2'b10) begin
              rd_op_d = 1'b1;
              state_d = S_PHYAD;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_SKIP;
            end
          end
        end
        S_PHYAD: begin
          sh_d  = sh_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd4) begin
            cnt_d   = 5'd0;
            state_d = S_REGAD;
            match_d = (sh_next[4:0] == phy_addr);
`ifdef MDIO_BROADCAST_EN
            // Broadcast address accepted for writes only; a read would collide.
            if (!rd_op_q && sh_next[4:0] == 5'd0) match_d = 1'b1;
`endif
          end
        end
        S_REGAD: begin
          sh_d  = sh_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd4) begin
            cnt_d      = 5'd0;
            state_d    = S_TA;
            reg_addr_d = sh_next[4:0];
            rd_d       = rd_op_q & match_q;
          end
        end
        S_TA: begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd1) begin
            cnt_d   = 5'd0;
            state_d = rd_op_q ? S_RDATA : S_WDATA;
          end
        end
        S_WDATA: begin
          sh_d  = sh_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            cnt_d   = 5'd0;
            wdata_d = sh_next;
            wr_d    = match_q;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
        S_RDATA: begin
          // Count data rises; the frame closes on the fall after the 16th.
          if (cnt_q != 5'd16) cnt_d = cnt_q + 5'd1;
        end
        S_SKIP: begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd27) begin
            cnt_d   = 5'd0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (fall) begin
      // Second turnaround bit: take the bus and drive 0.
      if (state_q == S_TA && cnt_q == 5'd1 && rd_op_q && match_q) begin
        oe_d  = 1'b1;
        out_d = 1'b0;
      end
      if (state_q == S_RDATA) begin
        if (cnt_q == 5'd16) begin
          oe_d    = 1'b0;
          out_d   = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = 5'd0;
          state_d = S_IDLE;
        end else if (rd_op_q && match_q) begin
          oe_d  = 1'b1;
          out_d = tx_q[15];
          tx_d  = {tx_q[14:0], 1'b0};
        end
      end
    end

    // Stalled-mdc watchdog: abandon the frame without any strobe.
    if (state_q != S_IDLE && !rise) begin
      if (TO_EN && to_q == TO_LAST) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        oe_d    = 1'b0;
        out_d   = 1'b0;
        cnt_d   = 5'd0;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mdc_sync_q  <= '0;
      mdio_sync_q <= '0;
      mdc_prev_q  <= 1'b0;
      cnt_q       <= '0;
      sh_q        <= '0;
      tx_q        <= '0;
      rd_op_q     <= 1'b0;
      match_q     <= 1'b0;
      busy_q      <= 1'b0;
      oe_q        <= 1'b0;
      out_q       <= 1'b0;
      reg_addr_q  <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      ferr_q      <= 1'b0;
      to_q        <= '0;
    end else begin
      state_q     <= state_d;
      mdc_sync_q  <= mdc_sync_d;
      mdio_sync_q <= mdio_sync_d;
      mdc_prev_q  <= mdc_prev_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      tx_q        <= tx_d;
      rd_op_q     <= rd_op_d;
      match_q     <= match_d;
      busy_q      <= busy_d;
      oe_q        <= oe_d;
      out_q       <= out_d;
      reg_addr_q  <= reg_addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      ferr_q      <= ferr_d;
      to_q        <= to_d;
    end
  end

  assign mdio_out  = out_q;
  assign mdio_oe   = oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr    = wr_q;
  assign reg_rd    = rd_q;
  assign busy      = busy_q;
  assign frame_err = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_mdio_peripheral.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdio_peripheral
//  Description : Self-checking bench for mdio_peripheral. An MDIO controller
//                model issues frames; expected register-port events go into a
//                scoreboard queue that a monitor drains as the DUT strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdio_peripheral;

  localparam int         HALF = 8;
  localparam logic [4:0] PHY  = 5'd3;
  localparam int         EV_WR = 0, EV_RD = 1, EV_ERR = 2;

  typedef struct {
    int         kind;
    logic [4:0] addr;
    logic [15:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mdc = 1'b0;
  logic        mdio_in = 1'b1;
  logic        mdio_out, mdio_oe;
  logic [4:0]  phy_addr = PHY;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr, reg_rd;
  logic [15:0] reg_rdata;
  logic        busy, frame_err;

  int          total = 0;
  int          bad   = 0;
  ev_t         exp_q[$];
  logic [15:0] model [32];
  logic [15:0] rf    [32];

  mdio_peripheral #(.SYNC_STAGES(2), .TIMEOUT_CYC(1024)) dut (
    .clk(clk), .reset(reset), .mdc(mdc), .mdio_in(mdio_in),
    .mdio_out(mdio_out), .mdio_oe(mdio_oe), .phy_addr(phy_addr),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr),
    .reg_rd(reg_rd), .reg_rdata(reg_rdata), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  assign reg_rdata = rf[reg_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: the register file follows the DUT; every strobe pops the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] = model[i];
    end else begin
      if (reg_wr && reg_rd) check("wr_rd_overlap", 1, 0);
      if (reg_wr || reg_rd || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {29'd0, frame_err, reg_rd, reg_wr}, 0);
        end else begin
          e = exp_q.pop_front();
          if (reg_wr) begin
            check("wr_kind", EV_WR, e.kind);
            check("wr_addr", {27'd0, reg_addr}, {27'd0, e.addr});
            check("wr_data", {16'd0, reg_wdata}, {16'd0, e.data});
            rf[reg_addr] = reg_wdata;
          end else if (reg_rd) begin
            check("rd_kind", EV_RD, e.kind);
            check("rd_addr", {27'd0, reg_addr}, {27'd0, e.addr});
          end else begin
            check("err_kind", EV_ERR, e.kind);
          end
        end
      end
    end
  end

  // One MDC period; the controller's view of the pad is taken just before the rise.
  task automatic mdc_cycle(input logic b, output logic s_oe, output logic s_out, output logic s_busy);
    mdio_in = b;
    repeat (HALF) @(negedge clk);
    s_oe   = mdio_oe;
    s_out  = mdio_out;
    s_busy = busy;
    mdc    = 1'b1;
    repeat (HALF) @(negedge clk);
    mdc    = 1'b0;
  endtask

  task automatic push_ev(input int kind, input logic [4:0] a, input logic [15:0] d);
    ev_t e;
    e.kind = kind; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  // Issue a Clause-22 frame (optionally truncated to nbits) and check the pad/busy behaviour.
  task automatic run_frame(input int npre, input logic [1:0] op, input logic [4:0] pa,
                           input logic [4:0] ra, input logic [15:0] wd, input int nbits);
    logic [31:0] fr;
    logic        is_wr, is_rd, wr_hit, rd_hit, exp_oe;
    logic        so, sd, sb, busy_last;
    logic [15:0] exp_word, got;
    int          oe_err;
    is_wr  = (op == 2'b01);
    is_rd  = (op == 2'b10);
    wr_hit = is_wr && (pa == PHY);
`ifdef MDIO_BROADCAST_EN
    if (is_wr && pa == 5'd0) wr_hit = 1'b1;
`endif
    rd_hit = is_rd && (pa == PHY);
    fr = {2'b01, op, pa, ra, (is_rd ? 2'b11 : 2'b10), (is_rd ? 16'hFFFF : wd)};
    exp_word = model[ra];
    if (nbits == 32 && wr_hit) begin
      push_ev(EV_WR, ra, wd);
      model[ra] = wd;
    end
    if (nbits >= 14 && rd_hit) push_ev(EV_RD, ra, 16'd0);
    if (nbits >= 4 && !is_wr && !is_rd) push_ev(EV_ERR, 5'd0, 16'd0);
    oe_err    = 0;
    got       = '0;
    busy_last = 1'b0;
    for (int i = 0; i < npre; i++) begin
      mdc_cycle(1'b1, so, sd, sb);
      if (so !== 1'b0) oe_err++;
    end
    for (int i = 0; i < nbits; i++) begin
      mdc_cycle(fr[31-i], so, sd, sb);
      busy_last = sb;
      exp_oe = rd_hit && (i >= 15);
      if (so !== exp_oe) oe_err++;
      if (exp_oe && i == 15 && sd !== 1'b0) oe_err++;
      if (exp_oe && i >= 16) got = {got[14:0], sd};
    end
    if (is_rd) mdio_in = 1'b1;
    check("oe_pattern", oe_err, 0);
    if (nbits == 32 && rd_hit) check("rdata", {16'd0, got}, {16'd0, exp_word});
    if (nbits >= 4) check("busy_in_frame", {31'd0, busy_last}, 1);
    if (nbits == 32) begin
      repeat (HALF + 6) @(negedge clk);
      check("busy_after", {31'd0, busy}, 0);
      check("oe_after", {31'd0, mdio_oe}, 0);
    end
  endtask

  initial begin
    logic so, sd, sb;
    for (int i = 0; i < 32; i++) model[i] = 16'($urandom);
    model[2] = 16'h1234;

    // Reset values while reset is held low.
    repeat (5) @(negedge clk);
    check("rst_mdio_out", {31'd0, mdio_out}, 0);
    check("rst_mdio_oe", {31'd0, mdio_oe}, 0);
    check("rst_reg_addr", {27'd0, reg_addr}, 0);
    check("rst_reg_wdata", {16'd0, reg_wdata}, 0);
    check("rst_reg_wr", {31'd0, reg_wr}, 0);
    check("rst_reg_rd", {31'd0, reg_rd}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_frame_err", {31'd0, frame_err}, 0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Long preamble write.
    run_frame(32, 2'b01, PHY, 5'd4, 16'hBEEF, 32);
    check("hold_reg_addr", {27'd0, reg_addr}, 32'd4);
    check("hold_reg_wdata", {16'd0, reg_wdata}, 32'hBEEF);

    // Read of reg 2.
    run_frame(0, 2'b10, PHY, 5'd2, 16'h0000, 32);

    // Write to another PHY.
    run_frame(2, 2'b01, 5'd7, 5'd5, 16'h5555, 32);

    // Illegal opcode then a normal write.
    run_frame(1, 2'b11, PHY, 5'd1, 16'h0F0F, 32);
    run_frame(1, 2'b00, PHY, 5'd1, 16'hF0F0, 32);
    run_frame(4, 2'b01, PHY, 5'd4, 16'hBEEF, 32);

    // Reset in the middle of read data.
    run_frame(1, 2'b10, PHY, 5'd2, 16'h0000, 24);
    repeat (5) @(negedge clk);
    check("oe_before_reset", {31'd0, mdio_oe}, 1);
    reset = 1'b0;
    @(negedge clk);
    check("oe_at_reset", {31'd0, mdio_oe}, 0);
    check("busy_at_reset", {31'd0, busy}, 0);
    mdio_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    run_frame(1, 2'b01, PHY, 5'd9, 16'hC0DE, 32);

    // Stalled MDC after REGAD.
    run_frame(1, 2'b01, PHY, 5'd6, 16'h7777, 14);
    repeat (1100) @(negedge clk);
    check("busy_after_timeout", {31'd0, busy}, 0);
    check("oe_after_timeout", {31'd0, mdio_oe}, 0);
    run_frame(1, 2'b10, PHY, 5'd9, 16'h0000, 32);

    // Write to PHYAD 0 and a read to PHYAD 0.
    run_frame(1, 2'b01, 5'd0, 5'd11, 16'hA5A5, 32);
    run_frame(1, 2'b10, 5'd0, 5'd11, 16'h0000, 32);
    run_frame(1, 2'b10, PHY, 5'd11, 16'h0000, 32);

    // Randomized traffic.
    for (int k = 0; k < 24; k++) begin
      int          r;
      logic [1:0]  op;
      logic [4:0]  pa;
      r  = int'($urandom_range(0, 9));
      op = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
      pa = ($urandom_range(0, 1) == 1) ? PHY : 5'($urandom_range(0, 31));
      run_frame(int'($urandom_range(0, 3)), op, pa, 5'($urandom_range(0, 31)),
                16'($urandom), 32);
    end

    mdc_cycle(1'b1, so, sd, sb);
    repeat (20) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
